// File: rtl/uart_pkg.sv
// uart_pkg: constants and TX state type shared by the UART receive and transmit paths
package uart_pkg;
  localparam logic [13:0] BAUD_DIV_9600 = 14'd10416;
  localparam logic [13:0] BAUD_DIV_CAP = 14'd5208;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_tx_path_if.sv
// uart_tx_path_if: valid/ready byte handshake into the UART transmitter
interface uart_tx_path_if;
  logic [7:0] tx_data_i;
  logic tx_valid_i;
  logic tx_ready_o;
  modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
  modport slave (input tx_data_i, input tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO; the head is readable before the pop edge
module uart_tx_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic push,
  input  logic pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] level
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  always_ff @(posedge iclk or negedge irst_n)
    if (!irst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge iclk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  assign dout = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  // extra pointer MSB distinguishes full from empty when the indices match
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/uart_tx_path.sv
// uart_tx_path: buffered 8N1 UART transmitter, byte FIFO feeding a baud-timed shifter
module uart_tx_path import uart_pkg::*; #(
  parameter logic [13:0] BAUD_DIV = BAUD_DIV_9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic iclk,
  input  logic irst_n,
  uart_tx_path_if.slave tx,
  output logic uart_tx_o,
  output logic tx_busy_o,
  output logic tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  uart_tx_state_t state, state_n;
  logic [13:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, head;
  logic full, empty, pop, bit_end, line_d;
  assign tx.tx_ready_o = ~full;
  uart_tx_fifo #(.DW(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .iclk(iclk),
    .irst_n(irst_n),
    .push(tx.tx_valid_i),
    .pop(pop),
    .din(tx.tx_data_i),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level_o)
  );
  always_ff @(posedge iclk or negedge irst_n)
    if (!irst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      uart_tx_o <= line_d;
    end
  assign bit_end = cnt == BAUD_DIV - 14'd1;
  always_comb begin
    state_n = state;
    cnt_n = bit_end ? '0 : cnt + 14'd1;
    idx_n = idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_n = head;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        idx_n = idx + 3'd1;
        if (idx == 3'(DATA_BITS - 1)) state_n = STOP;
      end
      // a queued byte starts its frame straight after this stop bit
      STOP: if (bit_end) begin
        pop = ~empty;
        shift_n = empty ? shift : head;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  assign line_d = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign tx_busy_o = state != IDLE;
  assign tx_done_o = state == STOP && bit_end;
endmodule

// File: tb/tb_uart_tx_path.sv
// tb_uart_tx_path: random and directed bytes checked by an 8N1 line decoder and an offered-byte queue
module tb_uart_tx_path;
  localparam logic [13:0] BD = 14'd16;
  localparam int DEPTH = 4;
  localparam int BIT = 16;
  localparam int FRAME = 10 * BIT;
  logic iclk = 1'b0;
  logic irst_n = 1'b0;
  logic uart_tx_o, tx_busy_o, tx_done_o;
  logic [2:0] fifo_level_o;
  uart_tx_path_if tx_if();
  uart_tx_path #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .iclk(iclk),
    .irst_n(irst_n),
    .tx(tx_if),
    .uart_tx_o(uart_tx_o),
    .tx_busy_o(tx_busy_o),
    .tx_done_o(tx_done_o),
    .fifo_level_o(fifo_level_o)
  );
  always #5 iclk = ~iclk;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  bit mon_active = 1'b0;
  int mon_n = 0;
  logic [FRAME-1:0] wave;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_frame();
    logic [7:0] got, exp;
    int errs;
    logic ev;
    for (int i = 0; i < 8; i++) got[i] = wave[(i + 1) * BIT + BIT / 2];
    if (exp_q.size() == 0) begin
      check("frame_unexpected", {24'd0, got}, 32'h100);
    end else begin
      exp = exp_q.pop_front();
      errs = 0;
      for (int k = 0; k < 10; k++)
        for (int s = 0; s < BIT; s++) begin
          ev = k == 0 ? 1'b0 : k == 9 ? 1'b1 : exp[k - 1];
          if (wave[k * BIT + s] !== ev) errs++;
        end
      check("frame_wave_errs", errs, 0);
      check("frame_byte", {24'd0, got}, {24'd0, exp});
    end
  endtask
  always @(posedge iclk) cyc <= cyc + 1;
  always @(negedge iclk) begin
    if (tx_done_o) done_cnt++;
    if (!irst_n) mon_active = 1'b0;
    else begin
      if (!mon_active && !uart_tx_o) begin
        mon_active = 1'b1;
        mon_n = 0;
        starts.push_back(cyc);
      end
      if (mon_active) begin
        wave[mon_n] = uart_tx_o;
        mon_n++;
        if (mon_n == FRAME) begin
          check_frame();
          mon_active = 1'b0;
        end
      end
    end
  end
  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    tx_if.tx_data_i = b;
    tx_if.tx_valid_i = 1'b1;
    for (int i = 0; i < 3000 && !acc; i++) begin
      @(negedge iclk);
      acc = tx_if.tx_ready_o;
      @(posedge iclk);
      #1;
    end
    tx_if.tx_valid_i = 1'b0;
    tx_if.tx_data_i = 8'($urandom);
    check("send_accepted", {31'd0, acc}, 32'd1);
    if (acc) exp_q.push_back(b);
  endtask
  task automatic drain(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge iclk);
      if (exp_q.size() == 0 && !mon_active) break;
    end
    check("drain_in_time", {31'd0, i < limit}, 32'd1);
    repeat (2) @(posedge iclk);
    #1;
  endtask
  initial begin
    int d0;
    bit seen;
    logic [7:0] b;
    tx_if.tx_valid_i = 1'b0;
    tx_if.tx_data_i = 8'h00;
    repeat (3) @(posedge iclk);
    #1;
    check("rst_line", {31'd0, uart_tx_o}, 32'd1);
    check("rst_ready", {31'd0, tx_if.tx_ready_o}, 32'd1);
    check("rst_busy", {31'd0, tx_busy_o}, 32'd0);
    check("rst_done", {31'd0, tx_done_o}, 32'd0);
    check("rst_level", {29'd0, fifo_level_o}, 32'd0);
    @(negedge iclk) irst_n = 1'b1;
    @(posedge iclk);
    #1;
    d0 = done_cnt;
    send(8'hA5);
    check("single_level_push", {29'd0, fifo_level_o}, 32'd1);
    check("single_line_n0", {31'd0, uart_tx_o}, 32'd1);
    @(posedge iclk);
    #1;
    check("single_level_pop", {29'd0, fifo_level_o}, 32'd0);
    check("single_busy", {31'd0, tx_busy_o}, 32'd1);
    check("single_line_n1", {31'd0, uart_tx_o}, 32'd1);
    @(posedge iclk);
    #1;
    check("single_line_n2", {31'd0, uart_tx_o}, 32'd0);
    drain(400);
    check("single_done_pulses", done_cnt - d0, 32'd1);
    check("single_busy_after", {31'd0, tx_busy_o}, 32'd0);
    check("single_idle_line", {31'd0, uart_tx_o}, 32'd1);
    starts.delete();
    d0 = done_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    drain(1000);
    check("burst_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("burst_gap1", starts[1] - starts[0], FRAME);
      check("burst_gap2", starts[2] - starts[1], FRAME);
    end
    check("burst_done_pulses", done_cnt - d0, 32'd3);
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom));
      if (i == 4) begin
        check("full_level", {29'd0, fifo_level_o}, 32'd4);
        check("full_ready", {31'd0, tx_if.tx_ready_o}, 32'd0);
      end
    end
    drain(2000);
    send(8'h11);
    send(8'h22);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge iclk);
      seen = tx_done_o;
    end
    check("simul_done_seen", {31'd0, seen}, 32'd1);
    check("simul_level_before", {29'd0, fifo_level_o}, 32'd1);
    tx_if.tx_data_i = 8'h33;
    tx_if.tx_valid_i = 1'b1;
    @(posedge iclk);
    #1;
    tx_if.tx_valid_i = 1'b0;
    exp_q.push_back(8'h33);
    check("simul_level_after", {29'd0, fifo_level_o}, 32'd1);
    drain(1000);
    send(8'hF0);
    send(8'h99);
    repeat (70) @(posedge iclk);
    #3;
    check("rst_mid_line_before", {31'd0, uart_tx_o}, 32'd0);
    d0 = done_cnt;
    irst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_line", {31'd0, uart_tx_o}, 32'd1);
    check("rst_mid_level", {29'd0, fifo_level_o}, 32'd0);
    check("rst_mid_busy", {31'd0, tx_busy_o}, 32'd0);
    repeat (5) @(posedge iclk);
    @(negedge iclk) irst_n = 1'b1;
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    @(posedge iclk);
    #1;
    send(8'h3C);
    drain(400);
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      send(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge iclk);
      #1;
    end
    drain(2000);
    check("random_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
